// File: rtl/multdiv_pkg.sv
// Shared types for the multdiv unit: sequencer states and radix-4 Booth digit selects.
package multdiv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Addend select: nz = non-zero digit, two = 2x multiplicand, neg = subtract.
    typedef struct packed {
        logic neg;
        logic two;
        logic nz;
    } booth_sel_t;

    localparam booth_sel_t ZERO = booth_sel_t'(3'b000);
    localparam booth_sel_t P1   = booth_sel_t'(3'b001);
    localparam booth_sel_t P2   = booth_sel_t'(3'b011);
    localparam booth_sel_t M1   = booth_sel_t'(3'b101);
    localparam booth_sel_t M2   = booth_sel_t'(3'b111);

endpackage

// File: rtl/booth_multiplier_param_if.sv
// Start/result handshake bundle between the multdiv controller and the Booth multiplier.
interface booth_multiplier_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_result_hi;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_signed, data_operandA, data_operandB,
        input  data_result, data_result_hi, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_signed, data_operandA, data_operandB,
        output data_result, data_result_hi, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps a {b1, b0, guard} window to an addend select.
module booth_recode
    import multdiv_pkg::*;
(
    input  logic [2:0] i_window,
    output booth_sel_t o_sel_c
);

    always_comb begin
        o_sel_c = ZERO;
        case (i_window)
            3'b001, 3'b010: o_sel_c = P1;
            3'b011:         o_sel_c = P2;
            3'b100:         o_sel_c = M2;
            3'b101, 3'b110: o_sel_c = M1;
            default:        o_sel_c = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_multiplier_param.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
module booth_multiplier_param
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    booth_multiplier_param_if.slave  bus
);

    localparam int unsigned EW   = WIDTH + 2;
    localparam int unsigned ITER = WIDTH / 2 + 1;
    localparam int unsigned CW   = $clog2(ITER);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [EW-1:0]    r_m;
    logic [EW-1:0]    r_acc;
    logic [EW-1:0]    r_mpl;
    logic             r_guard;
    logic             r_signed;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_exc;
    logic             r_rdy;
    logic             r_busy;

    booth_sel_t       w_sel;
    logic [EW-1:0]    w_a_ext;
    logic [EW-1:0]    w_b_ext;
    logic [EW-1:0]    w_mag;
    logic [EW-1:0]    w_addend;
    logic [EW-1:0]    w_sum;
    logic [EW-1:0]    w_acc_nxt;
    logic [EW-1:0]    w_mpl_nxt;
    logic [2*EW-1:0]  w_full;
    logic             w_last;
    logic             w_exc;

    booth_recode u_recode (
        .i_window ({r_mpl[1:0], r_guard}),
        .o_sel_c  (w_sel)
    );

    // Operand extension to EW bits, selected by the mode presented with the start pulse.
    always_comb begin
        w_a_ext = bus.ctrl_signed ? {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA}
                                  : {2'b00, bus.data_operandA};
        w_b_ext = bus.ctrl_signed ? {{2{bus.data_operandB[WIDTH-1]}}, bus.data_operandB}
                                  : {2'b00, bus.data_operandB};
    end

    // One Booth step: add digit*M to the upper half, then arithmetic shift right by 2.
    always_comb begin
        w_mag     = w_sel.two ? {r_m[EW-2:0], 1'b0} : r_m;
        if (!w_sel.nz) begin
            w_mag = '0;
        end
        w_addend  = w_sel.neg ? (~w_mag + EW'(1)) : w_mag;
        w_sum     = r_acc + w_addend;
        w_acc_nxt = {{2{w_sum[EW-1]}}, w_sum[EW-1:2]};
        w_mpl_nxt = {w_sum[1:0], r_mpl[EW-1:2]};
        w_full    = {w_acc_nxt, w_mpl_nxt};
        w_last    = (r_cnt == CW'(ITER - 1));
        // Bits above the 2*WIDTH product are pure extension, so checking them too is harmless.
        w_exc     = r_signed ? !((&w_full[2*EW-1:WIDTH-1]) || !(|w_full[2*EW-1:WIDTH-1]))
                             : (|w_full[2*EW-1:WIDTH]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_mpl    <= '0;
            r_guard  <= 1'b0;
            r_signed <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                IDLE: ;
                RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_mpl   <= w_mpl_nxt;
                    r_guard <= r_mpl[1];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res_lo <= w_full[WIDTH-1:0];
                        r_res_hi <= w_full[2*WIDTH-1:WIDTH];
                        r_exc    <= w_exc;
                        r_rdy    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // A start pulse wins over the step above: fresh start, restart, or start on completion.
            if (bus.ctrl_MULT) begin
                r_state  <= RUN;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_m      <= w_a_ext;
                r_acc    <= '0;
                r_mpl    <= w_b_ext;
                r_guard  <= 1'b0;
                r_signed <= bus.ctrl_signed;
            end
        end
    end

    assign bus.data_result    = r_res_lo;
    assign bus.data_result_hi = r_res_hi;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Directed bench for booth_multiplier_param at WIDTH=32 and WIDTH=8.
module tb_booth_multiplier_param;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    booth_multiplier_param_if #(.WIDTH(32)) b32 ();
    booth_multiplier_param_if #(.WIDTH(8))  b8 ();

    booth_multiplier_param #(.WIDTH(32)) u_dut32 (.clock(clock), .reset(reset), .bus(b32));
    booth_multiplier_param #(.WIDTH(8))  u_dut8  (.clock(clock), .reset(reset), .bus(b8));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit is8, input logic go, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        if (is8) begin
            b8.ctrl_MULT     = go;
            b8.ctrl_signed   = sgn;
            b8.data_operandA = a[7:0];
            b8.data_operandB = b[7:0];
        end else begin
            b32.ctrl_MULT     = go;
            b32.ctrl_signed   = sgn;
            b32.data_operandA = a;
            b32.data_operandB = b;
        end
    endtask

    task automatic sample(input bit is8, output logic rdy, output logic bsy,
                          output logic [31:0] lo, output logic [31:0] hi, output logic exc);
        if (is8) begin
            rdy = b8.data_resultRDY;
            bsy = b8.busy;
            lo  = {24'h0, b8.data_result};
            hi  = {24'h0, b8.data_result_hi};
            exc = b8.data_exception;
        end else begin
            rdy = b32.data_resultRDY;
            bsy = b32.busy;
            lo  = b32.data_result;
            hi  = b32.data_result_hi;
            exc = b32.data_exception;
        end
    endtask

    // Start on one edge, scramble operands afterwards, then time and check the single ready pulse.
    task automatic run_op(input string tag, input bit is8, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_exc, input int exp_lat);
        logic rdy, bsy, exc;
        logic [31:0] lo, hi;
        int lat;
        lat = -1;
        @(negedge clock);
        drive(is8, 1'b1, sgn, a, b);
        @(negedge clock);
        drive(is8, 1'b0, ~sgn, $urandom, $urandom);
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clock);
            sample(is8, rdy, bsy, lo, hi, exc);
            if (n == 1) check({tag, "_busy"}, 64'(bsy), 64'd1);
            if (rdy) begin
                lat = n;
                check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
                check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
                check({tag, "_exc"}, 64'(exc), 64'(exp_exc));
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(negedge clock);
        sample(is8, rdy, bsy, lo, hi, exc);
        check({tag, "_rdy_one_cycle"}, 64'(rdy), 64'd0);
        check({tag, "_idle"}, 64'(bsy), 64'd0);
    endtask

    initial begin
        logic rdy, bsy, exc;
        logic [31:0] lo, hi;
        int pulses, lat;
        logic [31:0] lo_at;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        sample(1'b0, rdy, bsy, lo, hi, exc);
        check("rst32", {rdy, bsy, exc, lo, hi}, 64'h0);
        sample(1'b1, rdy, bsy, lo, hi, exc);
        check("rst8", {rdy, bsy, exc, lo, hi}, 64'h0);

        run_op("s_7xm3",     1'b0, 1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 17);
        run_op("s_min_xm1",  1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 17);
        run_op("u_max_sq",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 17);

        // Reset mid-run: outputs (currently non-zero) clear and no ready pulse follows.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFD);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sample(1'b0, rdy, bsy, lo, hi, exc);
        check("midrst_busy", 64'(bsy), 64'd0);
        check("midrst_outs", {rdy, exc, lo, hi}, 64'h0);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clock);
            if (b32.data_resultRDY) pulses++;
        end
        check("midrst_no_rdy", 64'(pulses), 64'd0);

        run_op("u_max_x1",   1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b0, 17);
        run_op("s_m1_x1",    1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 17);
        run_op("u_zero",     1'b0, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 17);

        // Restart: 5*6 abandoned eight cycles in, 3*4 restarted; exactly one pulse.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'd6);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (7) @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd4);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pulses = 0;
        lat    = -1;
        lo_at  = 32'h0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (b32.data_resultRDY) begin
                pulses++;
                if (lat < 0) begin
                    lat   = n;
                    lo_at = b32.data_result;
                end
            end
        end
        check("restart_pulses", 64'(pulses), 64'd1);
        check("restart_lat", 64'(lat), 64'd17);
        check("restart_lo", 64'(lo_at), 64'd12);

        // Start on the completion edge: 100*200 finishes while 9*9 begins.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd200);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (16) @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd9, 32'd9);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(1'b0, rdy, bsy, lo, hi, exc);
        check("b2b_rdy", 64'(rdy), 64'd1);
        check("b2b_lo_first", 64'(lo), 64'd20000);
        check("b2b_busy", 64'(bsy), 64'd1);
        lat = -1;
        for (int n = 1; n <= 30 && lat < 0; n++) begin
            @(negedge clock);
            if (b32.data_resultRDY) begin
                lat = n;
                check("b2b_lo_second", 64'(b32.data_result), 64'd81);
            end
        end
        check("b2b_lat", 64'(lat), 64'd17);

        run_op("w8_s_min_sq", 1'b1, 1'b1, 32'h80, 32'h80, 32'h00, 32'h40, 1'b1, 5);
        run_op("w8_s_zero",   1'b1, 1'b1, 32'h00, 32'h80, 32'h00, 32'h00, 1'b0, 5);
        run_op("w8_u_max_sq", 1'b1, 1'b0, 32'hFF, 32'hFF, 32'h01, 32'hFE, 1'b1, 5);
        run_op("w8_s_m3x5",   1'b1, 1'b1, 32'hFD, 32'h05, 32'hF1, 32'hFF, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_param.md
Name: booth_multiplier_param

Overview:
Parametrised radix-4 Booth sequential multiplier, the next generation of the fixed 32-bit multdiv multiplier. Generic even operand width, selectable signed/unsigned mode per operation, and a full double-width product. Explicit start/busy/ready handshake with a defined restart rule. Sits in the multdiv unit beside the divider and is driven by the same ctrl_MULT pulse.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4.
ITER, WIDTH/2+1, derived iteration count; localparam, not overridable.

Ports:
clock  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high; clears all state.
ctrl_MULT  input  1  start pulse; operands and mode sampled on this edge.
ctrl_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with ctrl_MULT.
data_operandA  input  WIDTH  multiplicand.
data_operandB  input  WIDTH  multiplier.
data_result  output  WIDTH  low WIDTH bits of product; registered.
data_result_hi  output  WIDTH  high WIDTH bits of product; registered.
data_exception  output  1  product does not fit in WIDTH bits for the sampled mode; registered.
data_resultRDY  output  1  one-cycle pulse: result outputs valid and updated.
busy  output  1  high while an operation is in progress.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0. Reset mid-operation aborts; no ready pulse follows.
- States: IDLE, RUN. DONE is not a state; completion returns to IDLE and pulses ready.
- IDLE: ctrl_MULT=1 loads operands, goes to RUN, sets counter=0 and busy=1 on the same edge (edge E0).
- Operand extension to WIDTH+2 bits: sign-extend in signed mode, zero-extend in unsigned mode.
- Accumulator: {acc_hi[WIDTH+1:0], mplier[WIDTH+1:0], guard=0}.
- RUN, one iteration per cycle:
  - Booth digit from {mplier[1:0], guard}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - acc_hi += digit*M, computed at WIDTH+2 bits.
  - Whole register arithmetic-shifts right by 2.
- After ITER iterations (edge E_ITER):
  - Result registers load the full product; data_resultRDY=1 for exactly one cycle (E_ITER to E_ITER+1).
  - busy drops to 0; state returns to IDLE.
  - For WIDTH=32, ITER=17: ready is high in the 17th cycle after the start edge.
- Result outputs hold their value until the next completion or reset. They are not cleared between operations.
- Exception:
  - Signed mode: upper WIDTH+1 bits of the 2*WIDTH product are not all equal.
  - Unsigned mode: data_result_hi != 0.
  - Computed from the true product, so a zero operand never raises it.
- ctrl_MULT during RUN: restart. Operands and mode are re-sampled, counter resets, and the old operation is discarded with no ready pulse for it.
- ctrl_MULT on the completion edge E_ITER: the ready pulse still fires for the finished operation, and the new operation starts on the same edge.
- Operand inputs may change freely after the start edge.

Decomposition:
- Package multdiv_pkg: state enum (IDLE, RUN) and Booth digit encoding constants (ZERO, P1, P2, M1, M2).
- Sub-module booth_recode: combinational mapping of a 3-bit window to an addend select (zero/1x/2x, negate). Instantiated once.
- Counter and datapath stay inline.

Test Plan:
1. WIDTH=32, signed, 7 * -3 -> data_resultRDY pulses 17 cycles after start; data_result=0xFFFFFFEB, data_result_hi=0xFFFFFFFF, data_exception=0.
2. WIDTH=32, signed, 0x80000000 * 0xFFFFFFFF -> data_result=0x80000000, data_result_hi=0x00000000, data_exception=1.
3. WIDTH=32, unsigned, 0xFFFFFFFF * 0xFFFFFFFF -> data_result_hi=0xFFFFFFFE, data_result=0x00000001, data_exception=1.
4. WIDTH=32, unsigned 0xFFFFFFFF * 1 -> data_result=0xFFFFFFFF, data_result_hi=0, data_exception=0. Same operands signed (-1 * 1) -> data_result_hi=0xFFFFFFFF, data_exception=0.
5. Restart: start 5*6, reassert ctrl_MULT with 3*4 eight cycles later -> exactly one ready pulse, 17 cycles after the second start, with data_result=12. Separately, reset asserted mid-run -> busy=0 next cycle, no ready pulse, all outputs 0.
6. WIDTH=8, signed, 0x80 * 0x80 -> ready 5 cycles after start; data_result=0x00, data_result_hi=0x40, data_exception=1. WIDTH=8, 0 * 0x80 -> data_exception=0.
